// File: rtl/cache_ram_pkg.sv
// ----------------------------------------------------------------------------
// cache_ram_pkg
// Shared definitions for the cache RAM blocks:
//   - ST_IDLE / ST_CLEAR : sweep state machine encoding
//   - latency_legal()    : read-latency legality check used at elaboration
// ----------------------------------------------------------------------------
package cache_ram_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Only a single or double output register stage is supported.
  function automatic bit latency_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage : cache_ram_pkg

// File: rtl/sdpram_bytewise.sv
// ----------------------------------------------------------------------------
// sdpram_bytewise
// Behavioural simple-dual-port array intended to map onto distributed RAM.
// Ports:
//   clk   in  clock
//   we    in  per-byte write enable
//   waddr in  write address
//   wdata in  write data
//   raddr in  read address
//   rdata out read data (asynchronous, combinational from raddr)
// The array itself has no reset; the owner clears it with a sweep.
// ----------------------------------------------------------------------------
module sdpram_bytewise #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic [NUM_BYTES-1:0]  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Single process with a lane loop keeps the array single-driven.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (we[b]) begin
        mem[waddr][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule : sdpram_bytewise

// File: rtl/cache_sdpram.sv
// ----------------------------------------------------------------------------
// cache_sdpram
// Simple-dual-port cache RAM with byte write enables, same-cycle write-to-read
// forwarding, 1- or 2-cycle read latency and a built-in INIT_VALUE sweep.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   ena, wea         write enable and per-byte lane enables
//   addra, dina      write address / data
//   enb, addrb       read enable / address
//   doutb            registered read data (reset value INIT_VALUE)
//   init_req         pulse: start a sweep of the whole array
//   ready            high once the array has been swept and is usable
// ----------------------------------------------------------------------------
module cache_sdpram
  import cache_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int SIZE       = 256,
  parameter int LATENCY    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH,
  parameter int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [NUM_BYTES-1:0]  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb,
  input  logic                  init_req,
  output logic                  ready
);

  if (!latency_legal(LATENCY)) begin : g_bad_latency
    $error("cache_sdpram: LATENCY must be 1 or 2");
  end

  // --------------------------------------------------------------------------
  // Sweep FSM
  // --------------------------------------------------------------------------
  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  clearing;
  logic                  last_entry;

  assign clearing   = (state_q == ST_CLEAR);
  assign last_entry = (cnt_q == ADDR_WIDTH'(SIZE - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (clearing) begin
      if (last_entry) begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (init_req) begin
      state_d = ST_CLEAR;
      ready_d = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;

  // --------------------------------------------------------------------------
  // Array and write-port mux: the sweep owns the write port while clearing.
  // --------------------------------------------------------------------------
  logic [NUM_BYTES-1:0]  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign mem_we    = clearing ? {NUM_BYTES{1'b1}} : (ena ? wea : '0);
  assign mem_waddr = clearing ? cnt_q : addra;
  assign mem_wdata = clearing ? INIT_VALUE : dina;

  sdpram_bytewise #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .DEPTH      (SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_BYTES  (NUM_BYTES)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (addrb),
    .rdata (mem_rdata)
  );

  // --------------------------------------------------------------------------
  // Forwarding: the array is read-first, so a same-cycle write to the read
  // address is merged in per byte to give write-first behaviour.
  // --------------------------------------------------------------------------
  logic                  addr_hit;
  logic [DATA_WIDTH-1:0] rd_merged;
  logic [DATA_WIDTH-1:0] rd_data;

  assign addr_hit = ena && (addra == addrb);

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_fwd
    assign rd_merged[gi*BYTE_WIDTH +: BYTE_WIDTH] =
      (addr_hit && wea[gi]) ? dina[gi*BYTE_WIDTH +: BYTE_WIDTH]
                            : mem_rdata[gi*BYTE_WIDTH +: BYTE_WIDTH];
  end

  // Contents are undefined mid-sweep, so reads then report the cleared value.
  assign rd_data = clearing ? INIT_VALUE : rd_merged;

  // --------------------------------------------------------------------------
  // Output register stage(s)
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] dout_q;

  if (LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  s1_valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_data_q  <= INIT_VALUE;
        s1_valid_q <= 1'b0;
        dout_q     <= INIT_VALUE;
      end else begin
        s1_data_q  <= rd_data;
        s1_valid_q <= enb;
        if (s1_valid_q) begin
          dout_q <= s1_data_q;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= INIT_VALUE;
      end else if (enb) begin
        dout_q <= rd_data;
      end
    end
  end

  assign doutb = dout_q;

endmodule : cache_sdpram
